// File: rtl/rf_pkg.sv
// rf_pkg: shared write-back/register-file widths and partition codes.
package rf_pkg;
    localparam int RF_DATA_W = 64;
    localparam int RF_ADDR_W = 6;
    localparam int RF_PPP_W  = 3;
    localparam int RF_CNT_W  = 16;
    localparam logic [RF_PPP_W-1:0] PPP_FULL = 3'd0;
    localparam logic [RF_PPP_W-1:0] PPP_LO   = 3'd1;
    localparam logic [RF_PPP_W-1:0] PPP_HI   = 3'd2;
    localparam logic [RF_PPP_W-1:0] PPP_B0   = 3'd3;
    localparam logic [RF_PPP_W-1:0] PPP_B1   = 3'd4;
    localparam logic [RF_PPP_W-1:0] PPP_B2   = 3'd5;
    localparam logic [RF_PPP_W-1:0] PPP_B3   = 3'd6;
    localparam logic [RF_PPP_W-1:0] PPP_NONE = 3'd7;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer flips to the other side after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio_d, prio_q;
    always_comb begin
        gnt    = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
        prio_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : prio_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) prio_q <= 1'b0;
        else      prio_q <= prio_d;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates two write-back requesters onto one registered reg_file write port.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int PPP_W  = RF_PPP_W,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [PPP_W-1:0]  req0_ppp,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [PPP_W-1:0]  req1_ppp,
    output logic              req1_ready,
    input  logic              wb_hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] in_addr,
    output logic [DATA_W-1:0] in_data,
    output logic [PPP_W-1:0]  ppp,
    input  logic [ADDR_W-1:0] addr_r1,
    input  logic [ADDR_W-1:0] addr_r2,
    output logic              hazard_r1,
    output logic              hazard_r2,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);
    logic [1:0]        req, gnt;
    logic              wr_en_d, wr_en_q;
    logic [ADDR_W-1:0] in_addr_d, in_addr_q;
    logic [DATA_W-1:0] in_data_d, in_data_q;
    logic [PPP_W-1:0]  ppp_d, ppp_q;
    logic [CNT_W-1:0]  gnt_cnt0_d, gnt_cnt0_q, gnt_cnt1_d, gnt_cnt1_q;
    // Requests never reach the arbiter during reset or hold, so no grant can move prio then.
    assign req = {req1_valid, req0_valid} & {2{rst & ~wb_hold}};
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );
    always_comb begin
        wr_en_d    = |gnt;
        in_addr_d  = gnt[1] ? req1_addr : gnt[0] ? req0_addr : in_addr_q;
        in_data_d  = gnt[1] ? req1_data : gnt[0] ? req0_data : in_data_q;
        ppp_d      = gnt[1] ? req1_ppp  : gnt[0] ? req0_ppp  : ppp_q;
        gnt_cnt0_d = (gnt[0] && gnt_cnt0_q != '1) ? gnt_cnt0_q + 1'b1 : gnt_cnt0_q;
        gnt_cnt1_d = (gnt[1] && gnt_cnt1_q != '1) ? gnt_cnt1_q + 1'b1 : gnt_cnt1_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en_q    <= 1'b0;
            in_addr_q  <= '0;
            in_data_q  <= '0;
            ppp_q      <= '0;
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            in_addr_q  <= in_addr_d;
            in_data_q  <= in_data_d;
            ppp_q      <= ppp_d;
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign wr_en      = wr_en_q;
    assign in_addr    = in_addr_q;
    assign in_data    = in_data_q;
    assign ppp        = ppp_q;
    assign gnt_cnt0   = gnt_cnt0_q;
    assign gnt_cnt1   = gnt_cnt1_q;
    assign hazard_r1  = rst & wr_en_q & (addr_r1 == in_addr_q);
    assign hazard_r2  = rst & wr_en_q & (addr_r2 == in_addr_q);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table-driven directed check of rf_wb_arbiter with a 2-bit grant counter.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready, wb_hold;
    logic [5:0]  req0_addr, req1_addr, in_addr, addr_r1, addr_r2;
    logic [63:0] req0_data, req1_data, in_data;
    logic [2:0]  req0_ppp, req1_ppp, ppp;
    logic        wr_en, hazard_r1, hazard_r2;
    logic [1:0]  gnt_cnt0, gnt_cnt1;
    int          n_chk = 0;
    int          n_fail = 0;

    rf_wb_arbiter #(.DATA_W(64), .ADDR_W(6), .PPP_W(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ppp(req0_ppp), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ppp(req1_ppp), .req1_ready(req1_ready),
        .wb_hold(wb_hold), .wr_en(wr_en), .in_addr(in_addr), .in_data(in_data), .ppp(ppp),
        .addr_r1(addr_r1), .addr_r2(addr_r2), .hazard_r1(hazard_r1), .hazard_r2(hazard_r2),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v0, v1, hold;
        logic [5:0] a0, a1, ar1, ar2;
        logic er0, er1, eh1, eh2, ewr;
        logic [5:0] eaddr;
        logic [63:0] edata;
        logic [2:0] eppp;
        logic [1:0] c0, c1;
    } vec_t;
    vec_t tv[17];

    function automatic logic [63:0] d0f(input logic [5:0] a);
        return 64'hA0A0_0000_0000_0000 | {58'd0, a};
    endfunction
    function automatic logic [63:0] d1f(input logic [5:0] a);
        return 64'hB1B1_0000_0000_0000 | {58'd0, a};
    endfunction
    function automatic vec_t mk(input logic v0, v1, hold, input logic [5:0] a0, a1, ar1, ar2,
                                input logic er0, er1, eh1, eh2, ewr, input logic [5:0] eaddr,
                                input logic [63:0] edata, input logic [2:0] eppp,
                                input logic [1:0] c0, c1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.hold = hold; v.a0 = a0; v.a1 = a1; v.ar1 = ar1; v.ar2 = ar2;
        v.er0 = er0; v.er1 = er1; v.eh1 = eh1; v.eh2 = eh2; v.ewr = ewr;
        v.eaddr = eaddr; v.edata = edata; v.eppp = eppp; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " wr_en"}, {63'd0, wr_en}, 64'd0);
        chk({tag, " in_addr"}, {58'd0, in_addr}, 64'd0);
        chk({tag, " in_data"}, in_data, 64'd0);
        chk({tag, " ppp"}, {61'd0, ppp}, 64'd0);
        chk({tag, " cnt0"}, {62'd0, gnt_cnt0}, 64'd0);
        chk({tag, " cnt1"}, {62'd0, gnt_cnt1}, 64'd0);
    endtask

    initial begin
        tv[0]  = mk(1,1,0, 13,12, 0, 0,  1,0, 0,0, 1, 13, d0f(13), 3'd5, 1,0);
        tv[1]  = mk(1,1,0, 13,12, 13,12, 0,1, 1,0, 1, 12, d1f(12), 3'd2, 1,1);
        tv[2]  = mk(1,1,0, 13,12, 13,12, 1,0, 0,1, 1, 13, d0f(13), 3'd5, 2,1);
        tv[3]  = mk(1,1,0, 13,12, 13,13, 0,1, 1,1, 1, 12, d1f(12), 3'd2, 2,2);
        tv[4]  = mk(0,0,0, 22,0,  12,9,  0,0, 1,0, 0, 12, d1f(12), 3'd2, 2,2);
        tv[5]  = mk(0,0,0, 0,0,   12,9,  0,0, 0,0, 0, 12, d1f(12), 3'd2, 2,2);
        tv[6]  = mk(0,1,0, 0,22,  0,0,   0,1, 0,0, 1, 22, d1f(22), 3'd2, 2,3);
        tv[7]  = mk(0,0,0, 0,0,   22,9,  0,0, 1,0, 0, 22, d1f(22), 3'd2, 2,3);
        tv[8]  = mk(0,0,0, 0,0,   22,9,  0,0, 0,0, 0, 22, d1f(22), 3'd2, 2,3);
        tv[9]  = mk(1,1,1, 5,6,   22,9,  0,0, 0,0, 0, 22, d1f(22), 3'd2, 2,3);
        tv[10] = mk(1,1,1, 5,6,   22,9,  0,0, 0,0, 0, 22, d1f(22), 3'd2, 2,3);
        tv[11] = mk(1,1,1, 5,6,   22,9,  0,0, 0,0, 0, 22, d1f(22), 3'd2, 2,3);
        tv[12] = mk(1,1,0, 5,6,   0,0,   1,0, 0,0, 1, 5,  d0f(5),  3'd5, 3,3);
        tv[13] = mk(0,1,0, 0,6,   5,0,   0,1, 1,0, 1, 6,  d1f(6),  3'd2, 3,3);
        tv[14] = mk(0,1,0, 0,7,   6,6,   0,1, 1,1, 1, 7,  d1f(7),  3'd2, 3,3);
        tv[15] = mk(1,0,0, 8,0,   7,8,   1,0, 1,0, 1, 8,  d0f(8),  3'd5, 3,3);
        tv[16] = mk(1,0,0, 9,0,   0,8,   1,0, 0,1, 1, 9,  d0f(9),  3'd5, 3,3);

        rst = 1'b0; wb_hold = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 6'd17; req1_addr = 6'd17;
        req0_data = 64'h1111; req1_data = 64'h2222;
        req0_ppp = 3'd5; req1_ppp = 3'd2;
        addr_r1 = 6'd0; addr_r2 = 6'd0;
        #1;
        chk("rst ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst haz1", {63'd0, hazard_r1}, 64'd0);
        cyc();
        cyc();
        chk_zero("rst");
        chk("rst ready0 held", {63'd0, req0_ready}, 64'd0);

        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            req0_valid = tv[i].v0; req1_valid = tv[i].v1; wb_hold = tv[i].hold;
            req0_addr = tv[i].a0; req1_addr = tv[i].a1;
            req0_data = d0f(tv[i].a0); req1_data = d1f(tv[i].a1);
            addr_r1 = tv[i].ar1; addr_r2 = tv[i].ar2;
            #1;
            chk($sformatf("v%0d ready0", i), {63'd0, req0_ready}, {63'd0, tv[i].er0});
            chk($sformatf("v%0d ready1", i), {63'd0, req1_ready}, {63'd0, tv[i].er1});
            chk($sformatf("v%0d haz1", i), {63'd0, hazard_r1}, {63'd0, tv[i].eh1});
            chk($sformatf("v%0d haz2", i), {63'd0, hazard_r2}, {63'd0, tv[i].eh2});
            cyc();
            chk($sformatf("v%0d wr_en", i), {63'd0, wr_en}, {63'd0, tv[i].ewr});
            chk($sformatf("v%0d in_addr", i), {58'd0, in_addr}, {58'd0, tv[i].eaddr});
            chk($sformatf("v%0d in_data", i), in_data, tv[i].edata);
            chk($sformatf("v%0d ppp", i), {61'd0, ppp}, {61'd0, tv[i].eppp});
            chk($sformatf("v%0d cnt0", i), {62'd0, gnt_cnt0}, {62'd0, tv[i].c0});
            chk($sformatf("v%0d cnt1", i), {62'd0, gnt_cnt1}, {62'd0, tv[i].c1});
        end

        // Reset lands on a staged write to 9: it must be dropped.
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 6'd17; addr_r1 = 6'd9;
        #1;
        chk("mid rst ready0", {63'd0, req0_ready}, 64'd0);
        chk("mid rst ready1", {63'd0, req1_ready}, 64'd0);
        chk("mid rst haz1", {63'd0, hazard_r1}, 64'd0);
        cyc();
        chk_zero("mid rst");

        rst = 1'b1; req1_valid = 1'b0; req0_valid = 1'b1; req0_addr = 6'd17;
        req0_data = 64'hDEAD_BEEF_0123_4567; req0_ppp = 3'd0; addr_r1 = 6'd0;
        #1;
        chk("first ready0", {63'd0, req0_ready}, 64'd1);
        chk("first ready1", {63'd0, req1_ready}, 64'd0);
        cyc();
        chk("first wr_en", {63'd0, wr_en}, 64'd1);
        chk("first in_addr", {58'd0, in_addr}, 64'd17);
        chk("first in_data", in_data, 64'hDEAD_BEEF_0123_4567);
        chk("first ppp", {61'd0, ppp}, 64'd0);
        chk("first cnt0", {62'd0, gnt_cnt0}, 64'd1);
        chk("first cnt1", {62'd0, gnt_cnt1}, 64'd0);

        req0_addr = 6'd30; req0_data = 64'h3030; req0_ppp = 3'd3;
        cyc();
        chk("pre-hold wr_en", {63'd0, wr_en}, 64'd1);
        chk("pre-hold in_addr", {58'd0, in_addr}, 64'd30);
        wb_hold = 1'b1; req0_addr = 6'd31; req0_data = 64'h3131; addr_r1 = 6'd30;
        #1;
        chk("hold ready0", {63'd0, req0_ready}, 64'd0);
        chk("hold staged wr_en", {63'd0, wr_en}, 64'd1);
        chk("hold staged haz1", {63'd0, hazard_r1}, 64'd1);
        cyc();
        chk("hold after wr_en", {63'd0, wr_en}, 64'd0);
        chk("hold after in_addr", {58'd0, in_addr}, 64'd30);
        chk("hold after in_data", in_data, 64'h3030);
        chk("hold after ppp", {61'd0, ppp}, 64'd3);
        chk("hold after cnt0", {62'd0, gnt_cnt0}, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, write-data width in bits.
REQ-002 Parameter ADDR_W, default 6, register address width in bits.
REQ-003 Parameter PPP_W, default 3, partition-code width in bits.
REQ-004 Parameter CNT_W, default 16, grant-counter width in bits.
REQ-005 Clocking and reset are fixed: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 req0_valid, req1_valid  input  1 each  write-back request from requester 0 and requester 1.
REQ-009 req0_addr, req1_addr  input  ADDR_W each  destination register address.
REQ-010 req0_data, req1_data  input  DATA_W each  write data.
REQ-011 req0_ppp, req1_ppp  input  PPP_W each  partition code, passed through unchanged.
REQ-012 req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-013 wb_hold  input  1  freeze the write port; no grants are issued while it is high.
REQ-014 wr_en, in_addr, in_data, ppp  output  1/ADDR_W/DATA_W/PPP_W  registered write port driven to reg_file.
REQ-015 addr_r1, addr_r2  input  ADDR_W each  reg_file read addresses, for the hazard check.
REQ-016 hazard_r1, hazard_r2  output  1 each  the read address matches the staged write.
REQ-017 gnt_cnt0, gnt_cnt1  output  CNT_W each  saturating count of accepted requests per requester.

Function
REQ-018 A request on port k is accepted in a cycle exactly when reqk_valid and reqk_ready are both 1.
REQ-019 At most one ready is asserted per cycle, and readyk is combinational: it requires reqk_valid=1, wb_hold=0 and a grant from the arbiter.
REQ-020 Single valid request with wb_hold=0: that requester is granted regardless of priority.
REQ-021 Both requests valid: the requester indicated by the priority pointer prio is granted.
REQ-022 After any grant to requester k, prio becomes 1-k; with no grant, prio holds.
REQ-023 An accepted request appears on wr_en/in_addr/in_data/ppp on the next rising edge (latency 1); wr_en=1 for exactly that one cycle.
REQ-024 In a cycle with no acceptance, the next wr_en=0; in_addr, in_data and ppp hold their previous values.
REQ-025 hazard_rN = wr_en AND (addr_rN == in_addr), combinational, with no dependence on ppp.
REQ-026 gnt_cntk increments by 1 on each acceptance from requester k and saturates at 2^CNT_W-1 (no wrap).
REQ-027 If wb_hold rises while a write is staged, that staged write still completes; hold only blocks new grants.
REQ-028 A request may be withdrawn (valid dropped) before acceptance; no state changes as a result.
REQ-029 Requests with equal addresses from both ports in one cycle are ordered only by arbitration; no merging takes place.

Reset
REQ-030 While rst=0 at a rising edge: wr_en=0, in_addr=0, in_data=0, ppp=0, prio=0, gnt_cnt0=gnt_cnt1=0.
REQ-031 While rst=0, req0_ready=req1_ready=0 and hazard_r1=hazard_r2=0.
REQ-032 A request presented during reset is not accepted and is not staged.
REQ-033 Reset asserted while a write is staged clears wr_en at that edge, so the write is dropped.

Structure
REQ-034 DATA_W, ADDR_W, PPP_W and CNT_W defaults, plus the PPP code constants, live in the shared package rf_pkg, which reg_file also uses.
REQ-035 The two-way round-robin grant logic and the prio register form one sub-module, rr_arb2; the write staging, counters and hazard compare stay in rf_wb_arbiter.

Verification
REQ-036 Reset, then only req0_valid=1 with addr=17, data=64'hDEAD_BEEF_0123_4567, ppp=0 -> req0_ready=1 that cycle; the next cycle shows wr_en=1, in_addr=17, in_data=64'hDEAD_BEEF_0123_4567; gnt_cnt0=1.
REQ-037 Both requests valid for 4 cycles, with addr0=13 and addr1=12 -> grants alternate 0,1,0,1; in_addr sequence 13,12,13,12; each counter ends at 2.
REQ-038 Staged write to 22 with addr_r1=22, addr_r2=9 -> hazard_r1=1 and hazard_r2=0; the following idle cycle gives hazard_r1=0.
REQ-039 wb_hold=1 for 3 cycles with both ports valid -> no ready and wr_en=0; on release, requester prio (0 after reset) is granted first.
REQ-040 With CNT_W forced to 2, 5 accepted req1 writes -> gnt_cnt1 sticks at 3; rst=0 asserted mid-stream -> all outputs return to the REQ-030 values on the next edge.
